game_tick_scheduler: RTL
========================

GAME_TICK_SCHEDULER -- requirements
Module: game_tick_scheduler

Interface
REQ-001 Parameter DIV_BLOCK, default 833333, SHALL be the clk cycles per blockieee tick (60 Hz at 50 MHz).
REQ-002 Parameter DIV_DDAVER, default 1666667, SHALL be the clk cycles per ddaver tick (30 Hz).
REQ-003 Parameter DIV_BULLET, default 555556, SHALL be the clk cycles per bullet tick (90 Hz).
REQ-004 Parameter TIMEOUT, default 4096, SHALL be the max clk cycles a grant may be held before forced release.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 pause  in  1  freezes tick counters when high.
REQ-008 vblank  in  1  high = new grants permitted.
REQ-009 req_done  in  1  granted updater finished; sampled only in BUSY.
REQ-010 grant  out  3  one-hot owner of shared game-state port; [0] blockieee, [1] ddaver, [2] bullet.
REQ-011 start  out  1  one-cycle pulse coincident with the first cycle of grant.
REQ-012 pending  out  3  tick awaiting service, same bit order as grant.
REQ-013 overrun  out  3  sticky: tick arrived while own pending already set.
REQ-014 timeout_err  out  1  sticky: a grant was force-released.

Function
REQ-015 Each channel x SHALL own a 21-bit counter: 0..DIV_x-1, wrapping to 0; it advances only when pause=0.
REQ-016 A tick SHALL occur on a cycle where counter_x==DIV_x-1 and pause=0; pending[x] goes 1 the next cycle.
REQ-017 Tick while pending[x]=1 and x not being selected that cycle: overrun[x] SHALL set; pending[x] stays 1; no tick counting.
REQ-018 Tick on the same cycle x is selected: pending[x] SHALL remain 1 (new tick wins) and overrun[x] SHALL NOT set.
REQ-019 FSM states SHALL be IDLE and BUSY only.
REQ-020 IDLE: when vblank=1 and pending!=0, SHALL select by fixed priority bullet > blockieee > ddaver, clear that pending bit, and enter BUSY.
REQ-021 On entry to BUSY, grant SHALL be the selected one-hot and start=1 for exactly that first cycle; grant appears one cycle after the selection cycle.
REQ-022 BUSY: grant SHALL hold constant; vblank and new ticks SHALL NOT alter it.
REQ-023 BUSY with req_done=1: grant SHALL be 0 next cycle and FSM SHALL return to IDLE; re-selection earliest the cycle after that (minimum one idle cycle between grants).
REQ-024 BUSY cycle count reaching TIMEOUT without req_done: SHALL force IDLE, grant=0 next cycle, set timeout_err.
REQ-025 req_done in IDLE SHALL be ignored.
REQ-026 pause SHALL NOT affect the FSM; pending ticks continue to be serviced.
REQ-027 grant SHALL never have more than one bit set.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst=1 SHALL force all counters 0, FSM IDLE, grant=0, start=0, pending=0, overrun=0, timeout_err=0 on the next edge, including mid-grant; rst outranks every other input.
REQ-030 Sticky flags SHALL clear only on rst.

Verification (DIV_BLOCK=4, DIV_DDAVER=8, DIV_BULLET=3, TIMEOUT=16)
REQ-031 Release rst, vblank=0, 24 cycles -> pending=3'b111 from first ticks; then overrun[2] and overrun[0] set, grant=0 throughout.
REQ-032 All three pending, raise vblank, req_done 2 cycles after each start -> grant order 3'b100, 3'b001, 3'b010; each start exactly one cycle; at least one grant=0 cycle between grants.
REQ-033 Grant held, req_done never asserted -> grant drops after 16 BUSY cycles; timeout_err=1 and stays 1 until rst.
REQ-034 pause=1 for 20 cycles with pending=0 -> no new pending bits, counters hold value; on pause=0 the first tick arrives after the remaining count.
REQ-035 Bullet tick coincident with bullet selection -> pending[2]=1 after grant starts, overrun[2]=0.
REQ-036 rst pulsed while grant=3'b001 -> next cycle all outputs 0; bullet's first tick arrives 3 cycles after rst deasserts.

Source files
------------

// File: rtl/game_tick_scheduler.sv
// Three free-running tick dividers (blockieee, ddaver, bullet) feeding a
// fixed-priority, one-owner-at-a-time grant of the shared game-state port.
module game_tick_scheduler #(
    parameter int DIV_BLOCK  = 833333,
    parameter int DIV_DDAVER = 1666667,
    parameter int DIV_BULLET = 555556,
    parameter int TIMEOUT    = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    input  logic       vblank,
    input  logic       req_done,
    output logic [2:0] grant,
    output logic       start,
    output logic [2:0] pending,
    output logic [2:0] overrun,
    output logic       timeout_err
);

    localparam logic [20:0] LAST_BLOCK  = 21'(DIV_BLOCK - 1);
    localparam logic [20:0] LAST_DDAVER = 21'(DIV_DDAVER - 1);
    localparam logic [20:0] LAST_BULLET = 21'(DIV_BULLET - 1);
    localparam int          TW          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] BUSY_LAST = TW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state_q, state_d;
    logic [20:0]   cnt_block_q, cnt_block_d;
    logic [20:0]   cnt_ddaver_q, cnt_ddaver_d;
    logic [20:0]   cnt_bullet_q, cnt_bullet_d;
    logic [TW-1:0] busy_q, busy_d;
    logic [2:0]    grant_q, grant_d;
    logic [2:0]    pend_q, pend_d;
    logic [2:0]    ovr_q, ovr_d;
    logic          start_q, start_d;
    logic          terr_q, terr_d;
    logic [2:0]    tick;
    logic [2:0]    sel;

    always_comb begin
        tick[0] = !pause && (cnt_block_q  == LAST_BLOCK);
        tick[1] = !pause && (cnt_ddaver_q == LAST_DDAVER);
        tick[2] = !pause && (cnt_bullet_q == LAST_BULLET);

        cnt_block_d  = cnt_block_q;
        cnt_ddaver_d = cnt_ddaver_q;
        cnt_bullet_d = cnt_bullet_q;
        if (!pause) begin
            cnt_block_d  = tick[0] ? '0 : cnt_block_q  + 21'd1;
            cnt_ddaver_d = tick[1] ? '0 : cnt_ddaver_q + 21'd1;
            cnt_bullet_d = tick[2] ? '0 : cnt_bullet_q + 21'd1;
        end
    end

    // busy_q counts completed BUSY cycles; the grant is held for at most TIMEOUT cycles.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        start_d = 1'b0;
        busy_d  = busy_q;
        terr_d  = terr_q;
        sel     = '0;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (vblank && (pend_q != 3'b000)) begin
                    if (pend_q[2])      sel = 3'b100;
                    else if (pend_q[0]) sel = 3'b001;
                    else                sel = 3'b010;
                    grant_d = sel;
                    start_d = 1'b1;
                    busy_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (req_done) begin
                    grant_d = '0;
                    state_d = IDLE;
                end else if (busy_q == BUSY_LAST) begin
                    grant_d = '0;
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    busy_d = busy_q + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // A fresh tick wins over the clear of the channel being selected this cycle.
    always_comb begin
        pend_d = (pend_q & ~sel) | tick;
        ovr_d  = ovr_q | (tick & pend_q & ~sel);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_block_q  <= '0;
            cnt_ddaver_q <= '0;
            cnt_bullet_q <= '0;
            busy_q       <= '0;
            grant_q      <= '0;
            pend_q       <= '0;
            ovr_q        <= '0;
            start_q      <= 1'b0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_block_q  <= cnt_block_d;
            cnt_ddaver_q <= cnt_ddaver_d;
            cnt_bullet_q <= cnt_bullet_d;
            busy_q       <= busy_d;
            grant_q      <= grant_d;
            pend_q       <= pend_d;
            ovr_q        <= ovr_d;
            start_q      <= start_d;
            terr_q       <= terr_d;
        end
    end

    assign grant       = grant_q;
    assign start       = start_q;
    assign pending     = pend_q;
    assign overrun     = ovr_q;
    assign timeout_err = terr_q;

endmodule
